segasys1_dl_ctrl: RTL and testbench

- Sequences the HPS ioctl download stream for the Sega System 1 core.
- Latches SYSMODE (index 1) and the DIP bytes (index 254).
- Forwards ROM bytes (index 0) to the core's ROM write port through a one-entry buffer, with ioctl_wait backpressure.
- Holds the game core in reset during a download and for a fixed stretch afterwards.

---
 rtl/segasys1_dl_pkg.sv | 16 +
 rtl/segasys1_rst_stretch.sv | 26 ++
 rtl/segasys1_dl_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_segasys1_dl_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_dl_pkg.sv
// Shared types and constants for the Sega System 1 download sequencer.
// Optional checksum feature: SEGASYS1_DL_CHECKSUM_EN (see segasys1_dl_ctrl).
package segasys1_dl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } dl_state_t;

   localparam logic [7:0] IDX_ROM  = 8'd0;
   localparam logic [7:0] IDX_MODE = 8'd1;
   localparam logic [7:0] IDX_DSW  = 8'd254;

endpackage

// File: rtl/segasys1_rst_stretch.sv
// Loadable down-counter; done pulses while enabled on the count of 1,
// which is the last cycle the game core is held in reset.
module segasys1_rst_stretch #(
   parameter logic [15:0] LOAD_VAL = 16'd4800
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [15:0] cnt;

   // Count down from LOAD_VAL while enabled, saturating at zero.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != 16'd0)) begin
         cnt <= cnt - 16'd1;
      end
   end

   assign done = en && (cnt <= 16'd1);

endmodule

// File: rtl/segasys1_dl_ctrl.sv
// HPS ioctl download sequencer for the Sega System 1 core.
// Define SEGASYS1_DL_CHECKSUM_EN to build the rom_sum adder.
module segasys1_dl_ctrl
   import segasys1_dl_pkg::*;
#(
   parameter int          ROM_AW   = 25,
   parameter logic [24:0] ROM_SIZE = 25'h1_0000,
   parameter logic [15:0] RST_HOLD = 16'd4800
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              rom_we,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [7:0]        rom_data,
   input  logic              rom_ack,
   output logic [7:0]        sysmode,
   output logic [63:0]       dsw,
   output logic              core_reset,
   output logic              loaded,
   output logic [1:0]        err,
   output logic [15:0]       rom_sum
);

   dl_state_t state;
   dl_state_t state_nxt;

   logic bufv;
   logic got_rom;

   logic enter_load;
   logic cnt_load;
   logic cnt_en;
   logic cnt_done;
   logic set_loaded;

   logic wr_rom;
   logic in_range;
   logic accept;
   logic oversize;
   logic overrun;

   logic wr_mode;
   logic wr_dsw;

   // ROM bytes are only taken while loading; a busy buffer is free again
   // if the core acknowledges in the same cycle.
   assign wr_rom   = ioctl_wr && (ioctl_index == IDX_ROM) && (state == LOAD);
   assign in_range = ioctl_addr < ROM_SIZE;
   assign accept   = wr_rom && in_range && (!bufv || rom_ack);
   assign oversize = wr_rom && !in_range;
   assign overrun  = wr_rom && in_range && bufv && !rom_ack;

   assign wr_mode = ioctl_wr && (ioctl_index == IDX_MODE)
                    && (ioctl_addr == 25'd0);
   assign wr_dsw  = ioctl_wr && (ioctl_index == IDX_DSW)
                    && (ioctl_addr[24:3] == 22'd0);

   assign rom_we     = bufv;
   assign ioctl_wait = bufv;

   segasys1_rst_stretch #(
      .LOAD_VAL (RST_HOLD)
   ) u_stretch (
      .clk   (clk_sys),
      .reset (reset),
      .load  (cnt_load),
      .en    (cnt_en),
      .done  (cnt_done)
   );

   // State register; reset parks in HOLD with the stretch counter primed.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a new download wins over finishing the hold.
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN: begin
            if (ioctl_download) state_nxt = LOAD;
         end
         LOAD: begin
            if (!ioctl_download) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!bufv) state_nxt = HOLD;
         end
         HOLD: begin
            if (ioctl_download) begin
               state_nxt = LOAD;
            end else if (cnt_done) begin
               state_nxt = RUN;
            end
         end
      endcase
   end

   // Per-state control strobes for the counter and sticky flags.
   always_comb begin
      enter_load = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      set_loaded = 1'b0;
      unique case (state)
         RUN: begin
            enter_load = ioctl_download;
         end
         LOAD: begin
         end
         DRAIN: begin
            cnt_load = !bufv;
         end
         HOLD: begin
            enter_load = ioctl_download;
            cnt_en     = 1'b1;
            set_loaded = (state_nxt == RUN);
         end
      endcase
   end

   // Registered core reset: low only while the sequencer sits in RUN.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         core_reset <= 1'b1;
      end else begin
         core_reset <= (state_nxt != RUN);
      end
   end

   // One-entry ROM write buffer; address/data only move on acceptance.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bufv     <= 1'b0;
         rom_addr <= '0;
         rom_data <= 8'd0;
      end else if (accept) begin
         bufv     <= 1'b1;
         rom_addr <= ioctl_addr[ROM_AW-1:0];
         rom_data <= ioctl_dout;
      end else if (rom_ack) begin
         bufv     <= 1'b0;
      end
   end

   // Sticky status: errors and got_rom restart with each download.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         err     <= 2'b00;
         got_rom <= 1'b0;
         loaded  <= 1'b0;
      end else begin
         if (enter_load) begin
            err     <= 2'b00;
            got_rom <= 1'b0;
         end else begin
            if (accept)   got_rom <= 1'b1;
            if (oversize) err[0]  <= 1'b1;
            if (overrun)  err[1]  <= 1'b1;
         end
         if (set_loaded && got_rom) loaded <= 1'b1;
      end
   end

   // SYSMODE and DIP bytes are latched whenever they are written.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sysmode <= 8'd0;
         dsw     <= {64{1'b1}};
      end else begin
         if (wr_mode) sysmode <= ioctl_dout;
         if (wr_dsw) dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
   end

`ifdef SEGASYS1_DL_CHECKSUM_EN
   // Additive checksum of accepted ROM bytes, wrapping at 16 bits.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_sum <= 16'd0;
      end else if (enter_load) begin
         rom_sum <= 16'd0;
      end else if (accept) begin
         rom_sum <= rom_sum + {8'd0, ioctl_dout};
      end
   end
`else
   assign rom_sum = 16'd0;
`endif

endmodule

// File: tb/tb_segasys1_dl_ctrl.sv
// Self-checking bench for segasys1_dl_ctrl: directed scenarios plus
// randomized downloads against a transaction-level reference model.
module tb_segasys1_dl_ctrl;

   localparam int P_RUN   = 0;
   localparam int P_LOAD  = 1;
   localparam int P_DRAIN = 2;
   localparam int P_HOLD  = 3;
   localparam int HOLD_N  = 4800;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        rom_we;
   logic [24:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ack;
   logic [7:0]  sysmode;
   logic [63:0] dsw;
   logic        core_reset;
   logic        loaded;
   logic [1:0]  err;
   logic [15:0] rom_sum;

   always #5 clk_sys = ~clk_sys;

   segasys1_dl_ctrl dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .rom_we         (rom_we),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_ack        (rom_ack),
      .sysmode        (sysmode),
      .dsw            (dsw),
      .core_reset     (core_reset),
      .loaded         (loaded),
      .err            (err),
      .rom_sum        (rom_sum)
   );

   int checks = 0;
   int errors = 0;

   // reference model
   int          m_ph;
   int          m_cnt;
   bit          m_bufv;
   logic [24:0] m_addr;
   logic [7:0]  m_data;
   logic [1:0]  m_err;
   logic [15:0] m_sum;
   logic [7:0]  m_sys;
   logic [7:0]  m_dsw [8];
   bit          m_got;
   bit          m_loaded;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] dsw_exp();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_dsw[i];
      return r;
   endfunction

   function automatic logic [15:0] sum_exp();
`ifdef SEGASYS1_DL_CHECKSUM_EN
      return m_sum;
`else
      return m_sum & 16'h0000;
`endif
   endfunction

   // Apply one clock edge of the specification's rules to the model.
   task automatic model_edge();
      bit ob;
      int oph;
      ob  = m_bufv;
      oph = m_ph;
      if (reset) begin
         m_ph = P_HOLD; m_cnt = HOLD_N; m_bufv = 0;
         m_addr = '0; m_data = '0; m_err = '0; m_sum = '0;
         m_sys = '0; m_got = 0; m_loaded = 0;
         for (int i = 0; i < 8; i++) m_dsw[i] = 8'hFF;
         return;
      end
      if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0)
         m_sys = ioctl_dout;
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
         m_dsw[ioctl_addr[2:0]] = ioctl_dout;
      if (ob && rom_ack) m_bufv = 0;
      if (oph == P_LOAD && ioctl_wr && ioctl_index == 8'd0) begin
         if (ioctl_addr >= 25'h1_0000) m_err[0] = 1'b1;
         else if (ob && !rom_ack) m_err[1] = 1'b1;
         else begin
            m_bufv = 1; m_addr = ioctl_addr; m_data = ioctl_dout;
            m_got = 1; m_sum = m_sum + {8'h00, ioctl_dout};
         end
      end
      case (oph)
         P_RUN, P_HOLD: begin
            if (ioctl_download) begin
               m_ph = P_LOAD; m_err = '0; m_sum = '0; m_got = 0;
            end else if (oph == P_HOLD) begin
               if (m_cnt == 1) begin
                  m_ph = P_RUN;
                  if (m_got) m_loaded = 1;
               end else m_cnt--;
            end
         end
         P_LOAD:  if (!ioctl_download) m_ph = P_DRAIN;
         P_DRAIN: if (!ob) begin m_ph = P_HOLD; m_cnt = HOLD_N; end
         default: ;
      endcase
   endtask

   task automatic cmp_all();
      chk("core_reset", core_reset, (m_ph != P_RUN));
      chk("rom_we", rom_we, m_bufv);
      chk("ioctl_wait", ioctl_wait, m_bufv);
      chk("rom_addr", rom_addr, m_addr);
      chk("rom_data", rom_data, m_data);
      chk("sysmode", sysmode, m_sys);
      chk("dsw", dsw, dsw_exp());
      chk("err", err, m_err);
      chk("loaded", loaded, m_loaded);
      chk("rom_sum", rom_sum, sum_exp());
   endtask

   task automatic step();
      @(posedge clk_sys);
      model_edge();
      #1;
      cmp_all();
   endtask

   task automatic wr_byte(input logic [7:0] i, input logic [24:0] a,
                          input logic [7:0] d, input logic k);
      ioctl_wr = 1; ioctl_index = i; ioctl_addr = a; ioctl_dout = d;
      rom_ack = k;
      step();
      ioctl_wr = 0; rom_ack = 0;
   endtask

   task automatic wait_run(input string tag);
      int n;
      n = 0;
      while (core_reset && n < HOLD_N + 200) begin
         rom_ack = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      rom_ack = 0;
      chk(tag, core_reset, 1'b0);
   endtask

   initial begin
      int n;
      int sel;
      reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_index = 0;
      ioctl_addr = 0; ioctl_dout = 0; rom_ack = 0;

      // reset values and hold length
      repeat (3) step();
      chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_sysmode", sysmode, 8'h00);
      chk("rst_core_reset", core_reset, 1'b1);
      reset = 0;
      n = 0;
      while (core_reset && n < HOLD_N + 10) begin
         step();
         n++;
      end
      chk("hold_len", n, HOLD_N);

      // sysmode / dsw capture
      ioctl_download = 1;
      step();
      wr_byte(8'd1, 25'd0, 8'h06, 0);
      wr_byte(8'd254, 25'd3, 8'hA5, 0);
      step();
      chk("sysmode_06", sysmode, 8'h06);
      chk("dsw_a5", dsw, 64'hFFFF_FFFF_A5FF_FFFF);
      chk("err_clean", err, 2'b00);

      // two ROM bytes acked three cycles after rom_we
      wr_byte(8'd0, 25'd0, 8'h11, 0);
      step(); step();
      chk("wait_b0", ioctl_wait, 1'b1);
      chk("wr_b0", {rom_addr, rom_data}, {25'd0, 8'h11});
      rom_ack = 1; step(); rom_ack = 0;
      wr_byte(8'd0, 25'd1, 8'h22, 0);
      step(); step();
      chk("wait_b1", ioctl_wait, 1'b1);
      chk("wr_b1", {rom_addr, rom_data}, {25'd1, 8'h22});
      rom_ack = 1; step(); rom_ack = 0;
`ifdef SEGASYS1_DL_CHECKSUM_EN
      chk("sum_33", rom_sum, 16'h0033);
`endif
      ioctl_download = 0;
      wait_run("run_after_dl");
      chk("loaded_set", loaded, 1'b1);

      // index 0 in RUN is ignored
      wr_byte(8'd0, 25'd3, 8'h55, 0);
      chk("run_ignore", rom_we, 1'b0);

      // oversize and overrun
      ioctl_download = 1;
      step();
      wr_byte(8'd0, 25'h1_0000, 8'h77, 0);
      chk("oversize_we", rom_we, 1'b0);
      chk("oversize_err", err, 2'b01);
      wr_byte(8'd0, 25'd5, 8'hAA, 0);
      wr_byte(8'd0, 25'd6, 8'hBB, 0);
      chk("overrun_err", err, 2'b11);
      chk("overrun_keep", rom_data, 8'hAA);
      rom_ack = 1; step(); rom_ack = 0;
      ioctl_download = 0;
      repeat (4) step();
      ioctl_download = 1;
      step();
      chk("err_restart", err, 2'b00);

      // same-cycle write and ack
      wr_byte(8'd0, 25'd7, 8'hC1, 0);
      wr_byte(8'd0, 25'd8, 8'hC2, 1);
      chk("same_we", rom_we, 1'b1);
      chk("same_wr", {rom_addr, rom_data}, {25'd8, 8'hC2});
      chk("same_err", err, 2'b00);
      rom_ack = 1; step(); rom_ack = 0;

      // reset mid-download with a full buffer
      wr_byte(8'd0, 25'd9, 8'hD1, 0);
      reset = 1; step(); reset = 0;
      chk("mid_rst_we", rom_we, 1'b0);
      chk("mid_rst_err", err, 2'b00);
      chk("mid_rst_sum", rom_sum, 16'h0000);
      step();
      wr_byte(8'd0, 25'd10, 8'hE5, 0);
      chk("post_rst_load", rom_we, 1'b1);
`ifdef SEGASYS1_DL_CHECKSUM_EN
      chk("post_rst_sum", rom_sum, 16'h00E5);
`endif
      rom_ack = 1; step(); rom_ack = 0;
      ioctl_download = 0;
      wait_run("run_after_rst");

      // randomized downloads
      for (int t = 0; t < 6; t++) begin
         ioctl_download = 1;
         for (int c = 0; c < 300; c++) begin
            rom_ack = 1'($urandom_range(0, 1));
            ioctl_wr = ($urandom_range(0, 2) == 0);
            if (ioctl_wr && ioctl_wait && $urandom_range(0, 3) != 0)
               ioctl_wr = 0;
            sel = $urandom_range(0, 5);
            ioctl_dout = 8'($urandom);
            if (sel < 3) begin
               ioctl_index = 8'd0;
               if ($urandom_range(0, 9) == 0)
                  ioctl_addr = 25'h1_0000 + 25'($urandom_range(0, 255));
               else
                  ioctl_addr = 25'(c);
            end else if (sel == 3) begin
               ioctl_index = 8'd1;
               ioctl_addr = 25'($urandom_range(0, 1));
            end else if (sel == 4) begin
               ioctl_index = 8'd254;
               ioctl_addr = 25'($urandom_range(0, 15));
            end else begin
               ioctl_index = 8'd7;
               ioctl_addr = 25'($urandom_range(0, 7));
            end
            step();
         end
         ioctl_wr = 0; rom_ack = 0;
         ioctl_download = 0;
         if (t % 2 == 0) begin
            wait_run("run_random");
         end else begin
            for (int k = 0; k < 60; k++) begin
               rom_ack = 1'($urandom_range(0, 1));
               step();
            end
            rom_ack = 0;
         end
      end
      ioctl_download = 0;
      wait_run("run_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
